jk_excitation_driver: RTL and testbench
=======================================

// Module: jk_excitation_driver
// PURPOSE
//  Inverse of a JK flip-flop bank: accepts target state words and generates the per-bit J/K
//  controls, using the JK excitation table, that move an external WIDTH-bit JK register to each
//  target. Reads back the register's Q after the update edge and flags mismatches.
//  Sits between a pattern source (valid/ready) and a bank of JK flops in the sequential-logic lab.
// PARAMETERS
//  WIDTH    8  bits per target word / number of JK flops driven
//  DC_FILL  0  value substituted for excitation don't-cares (0: set/reset only; 1: toggle)
//  CNT_W    8  width of the saturating mismatch counter
// PORTS
//  clk        in   1        rising-edge clock, shared with the JK bank
//  clr        in   1        synchronous active-high reset
//  in_valid   in   1        target word valid
//  in_ready   out  1        driver can accept a target word
//  in_target  in   WIDTH    desired next state of the JK bank
//  q_obs      in   WIDTH    current Q of the external JK bank
//  j_out      out  WIDTH    J inputs to the bank
//  k_out      out  WIDTH    K inputs to the bank
//  done       out  1        one-cycle pulse: readback compare finished
//  mismatch   out  1        valid with done: q_obs != target
//  err_sticky out  1        set on any mismatch; cleared only by clr or err_clr
//  err_clr    in   1        synchronous clear of err_sticky and err_count
//  err_count  out  CNT_W    saturating count of mismatches
// BEHAVIOUR
//  Reset (clr high at a clk edge): state=IDLE, j_out=0, k_out=0, done=0, mismatch=0,
//   err_sticky=0, err_count=0, target register=0. clr overrides every other input,
//   mid-transaction included: the word in flight is dropped and no done pulse is issued.
//  FSM: IDLE -> DRIVE -> CHECK -> IDLE. One word takes 3 cycles; no overlap.
//   IDLE : in_ready=1, j_out=k_out=0 (bank holds). in_valid&in_ready -> latch in_target -> DRIVE.
//   DRIVE: in_ready=0; j_out/k_out are registered outputs, computed from latched target and
//          q_obs sampled at the accepting edge. Per bit (q=current, t=target):
//            q=0,t=0: J=0,       K=DC_FILL
//            q=0,t=1: J=1,       K=DC_FILL
//            q=1,t=0: J=DC_FILL, K=1
//            q=1,t=1: J=DC_FILL, K=0
//          With DC_FILL=0, J=K=1 is never driven. The bank updates on the edge that ends DRIVE.
//          -> CHECK.
//   CHECK: j_out=k_out=0. Compare q_obs to latched target; registered done=1 and
//          mismatch=(q_obs!=target) for exactly one cycle, the cycle after CHECK. -> IDLE.
//  Latency: accepting edge T0; J/K valid during T1; done/mismatch high during T3 (in_ready
//   already high again in T3, so back-to-back words accept every 3 cycles).
//  q_obs changing during DRIVE is ignored (excitation already registered).
//  err_count increments by 1 on each mismatch, saturating at 2^CNT_W-1 (no wrap).
//   err_sticky set together with the increment.
//  err_clr and a mismatch in the same cycle: clear wins, then count=0 and sticky=0.
//  in_valid outside IDLE is ignored; the source must hold in_valid/in_target until in_ready.
// TESTING
//  1 Reset: assert clr 2 cycles mid-DRIVE -> j_out=k_out=0, in_ready=1, no done, err_count=0.
//  2 Set/reset: bank Q=8'h0F, target 8'hF0, DC_FILL=0 -> J=8'hF0, K=8'h0F in T1; T3 done=1, mismatch=0.
//  3 Toggle fill: DC_FILL=1, Q=8'hAA, target 8'hAA -> J=8'hAA, K=8'h55; bank stays 8'hAA, mismatch=0.
//  4 Fault: bank bit 0 stuck at 0, target 8'h01 -> mismatch=1, err_sticky=1, err_count=1.
//  5 Saturation: CNT_W=2, 5 faulty words -> err_count sticks at 3; err_clr with mismatch -> 0.
//  6 Back-to-back: in_valid held for 4 words -> accepts every 3 cycles, 4 done pulses, bank ends at 4th target.

Source files
------------

// File: rtl/jk_excitation_driver.sv
// Turns target state words into J/K controls for an external JK register bank,
// then reads the bank back one cycle after the update edge and tracks mismatches.
module jk_excitation_driver #(
    parameter int WIDTH   = 8,
    parameter bit DC_FILL = 1'b0,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_target,
    input  logic [WIDTH-1:0] q_obs,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             done,
    output logic             mismatch,
    output logic             err_sticky,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   target_reg, target_next;
    logic [WIDTH-1:0]   j_reg, j_next;
    logic [WIDTH-1:0]   k_reg, k_next;
    logic               done_reg, done_next;
    logic               mismatch_reg, mismatch_next;
    logic               err_sticky_reg, err_sticky_next;
    logic [CNT_W-1:0]   err_count_reg, err_count_next;

    logic [WIDTH-1:0]   exc_j;
    logic [WIDTH-1:0]   exc_k;
    logic               mis_event;

    // Excitation table per bit; the don't-care side of each row takes DC_FILL.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_exc
            assign exc_j[gi] = q_obs[gi] ? DC_FILL : in_target[gi];
            assign exc_k[gi] = q_obs[gi] ? ~in_target[gi] : DC_FILL;
        end
    endgenerate

    assign mis_event = (state_reg == CHECK) && (q_obs != target_reg);

    always_comb begin
        state_next    = state_reg;
        target_next   = target_reg;
        j_next        = '0;
        k_next        = '0;
        done_next     = 1'b0;
        mismatch_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    target_next = in_target;
                    j_next      = exc_j;
                    k_next      = exc_k;
                    state_next  = DRIVE;
                end
            end
            DRIVE: begin
                state_next = CHECK;
            end
            CHECK: begin
                done_next     = 1'b1;
                mismatch_next = mis_event;
                state_next    = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A clear in the same cycle as a mismatch leaves the error state empty.
    always_comb begin
        err_sticky_next = err_sticky_reg;
        err_count_next  = err_count_reg;
        if (err_clr) begin
            err_sticky_next = 1'b0;
            err_count_next  = '0;
        end else if (mis_event) begin
            err_sticky_next = 1'b1;
            if (err_count_reg != CNT_MAX) begin
                err_count_next = err_count_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg      <= IDLE;
            target_reg     <= '0;
            j_reg          <= '0;
            k_reg          <= '0;
            done_reg       <= 1'b0;
            mismatch_reg   <= 1'b0;
            err_sticky_reg <= 1'b0;
            err_count_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            target_reg     <= target_next;
            j_reg          <= j_next;
            k_reg          <= k_next;
            done_reg       <= done_next;
            mismatch_reg   <= mismatch_next;
            err_sticky_reg <= err_sticky_next;
            err_count_reg  <= err_count_next;
        end
    end

    assign in_ready   = (state_reg == IDLE);
    assign j_out      = j_reg;
    assign k_out      = k_reg;
    assign done       = done_reg;
    assign mismatch   = mismatch_reg;
    assign err_sticky = err_sticky_reg;
    assign err_count  = err_count_reg;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: two instances (set/reset fill with 8-bit counter,
// toggle fill with 2-bit counter) each driving its own behavioural JK bank.
module tb_jk_excitation_driver;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_target = 8'h00;
    logic       err_clr = 1'b0;

    logic       in_ready0, in_ready1;
    logic [7:0] j0, k0, j1, k1;
    logic       done0, done1, mis0, mis1, sticky0, sticky1;
    logic [7:0] cnt_o0;
    logic [1:0] cnt_o1;

    logic [7:0] bank0 = 8'h00;
    logic [7:0] bank1 = 8'h00;
    logic       preload_en = 1'b0;
    logic [7:0] preload_val = 8'h00;
    logic [7:0] stuck = 8'h00;
    int         done_cnt = 0;

    int passes = 0;
    int checks = 0;

    int  m_cnt0 = 0;
    int  m_cnt1 = 0;
    bit  m_st0 = 1'b0;
    bit  m_st1 = 1'b0;

    always #5 clk = ~clk;

    jk_excitation_driver #(.WIDTH(8), .DC_FILL(1'b0), .CNT_W(8)) dut0 (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready0),
        .in_target(in_target), .q_obs(bank0), .j_out(j0), .k_out(k0),
        .done(done0), .mismatch(mis0), .err_sticky(sticky0),
        .err_clr(err_clr), .err_count(cnt_o0)
    );

    jk_excitation_driver #(.WIDTH(8), .DC_FILL(1'b1), .CNT_W(2)) dut1 (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready1),
        .in_target(in_target), .q_obs(bank1), .j_out(j1), .k_out(k1),
        .done(done1), .mismatch(mis1), .err_sticky(sticky1),
        .err_clr(err_clr), .err_count(cnt_o1)
    );

    // External JK banks (characteristic equation), with optional stuck-at-0 bits.
    always @(posedge clk) begin
        if (preload_en) begin
            bank0 <= preload_val;
            bank1 <= preload_val;
        end else begin
            bank0 <= ((j0 & ~bank0) | (~k0 & bank0)) & ~stuck;
            bank1 <= ((j1 & ~bank1) | (~k1 & bank1)) & ~stuck;
        end
        if (done0) done_cnt <= done_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        else
            passes++;
    endtask

    // Reference excitation: straight from the excitation table, row by row.
    function automatic void ref_exc(input logic [7:0] q, input logic [7:0] t, input bit dc,
                                    output logic [7:0] j, output logic [7:0] k);
        for (int i = 0; i < 8; i++) begin
            if (!q[i] && !t[i])      begin j[i] = 1'b0; k[i] = dc;   end
            else if (!q[i] && t[i])  begin j[i] = 1'b1; k[i] = dc;   end
            else if (q[i] && !t[i])  begin j[i] = dc;   k[i] = 1'b1; end
            else                     begin j[i] = dc;   k[i] = 1'b0; end
        end
    endfunction

    // Starts at a falling edge with both DUTs idle; ends at the falling edge of the done cycle.
    task automatic do_word(input logic [7:0] qp, input logic [7:0] t, input logic [7:0] stk,
                           input logic ec, input logic [7:0] ej0, input logic [7:0] ek0,
                           input logic [7:0] ej1, input logic [7:0] ek1, input logic emis);
        preload_en = 1'b1; preload_val = qp; stuck = 8'h00;
        @(negedge clk);
        preload_en = 1'b0;
        stuck = stk; in_valid = 1'b1; in_target = t;
        @(negedge clk);
        in_valid = 1'b0;
        chk("ready_drive", {30'd0, in_ready1, in_ready0}, 32'd0);
        chk("j_dc0", j0, ej0);
        chk("k_dc0", k0, ek0);
        chk("j_dc1", j1, ej1);
        chk("k_dc1", k1, ek1);
        @(negedge clk);
        err_clr = ec;
        chk("done_early", {30'd0, done1, done0}, 32'd0);
        @(negedge clk);
        err_clr = 1'b0;
        if (ec) begin
            m_cnt0 = 0; m_cnt1 = 0; m_st0 = 1'b0; m_st1 = 1'b0;
        end else if (emis) begin
            m_cnt0 = (m_cnt0 < 255) ? m_cnt0 + 1 : 255;
            m_cnt1 = (m_cnt1 < 3) ? m_cnt1 + 1 : 3;
            m_st0 = 1'b1; m_st1 = 1'b1;
        end
        $display("word q=%h t=%h stuck=%h clr_err=%0d j0=%h k0=%h j1=%h k1=%h mis=%0d cnt0=%0d cnt1=%0d",
                 qp, t, stk, ec, ej0, ek0, ej1, ek1, emis, m_cnt0, m_cnt1);
        chk("done", {30'd0, done1, done0}, 32'd3);
        chk("mismatch0", mis0, emis);
        chk("mismatch1", mis1, emis);
        chk("err_count0", cnt_o0, m_cnt0);
        chk("err_count1", cnt_o1, m_cnt1);
        chk("err_sticky0", sticky0, m_st0);
        chk("err_sticky1", sticky1, m_st1);
        chk("ready_done", {30'd0, in_ready1, in_ready0}, 32'd3);
    endtask

    typedef struct {
        logic [7:0] q_pre;
        logic [7:0] target;
        logic [7:0] stk;
        logic [7:0] j_dc0;
        logic [7:0] k_dc0;
        logic [7:0] j_dc1;
        logic [7:0] k_dc1;
        logic       mis;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [7:0] rq, rt, rs, ej0, ek0, ej1, ek1;
        logic       rc;
        logic [7:0] words [4];

        vecs[0] = '{8'h0F, 8'hF0, 8'h00, 8'hF0, 8'h0F, 8'hFF, 8'hFF, 1'b0};
        vecs[1] = '{8'hAA, 8'hAA, 8'h00, 8'h00, 8'h00, 8'hAA, 8'h55, 1'b0};
        vecs[2] = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h01, 8'hFF, 1'b1};
        vecs[3] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 1'b0};
        vecs[4] = '{8'h3C, 8'h5A, 8'h00, 8'h42, 8'h24, 8'h7E, 8'hE7, 1'b0};
        vecs[5] = '{8'h00, 8'h80, 8'h80, 8'h80, 8'h00, 8'h80, 8'hFF, 1'b1};

        // Power-on reset
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", {30'd0, in_ready1, in_ready0}, 32'd3);
        chk("rst_jk", {j0, k0, j1, k1}, 32'd0);
        chk("rst_done", {28'd0, done1, done0, mis1, mis0}, 32'd0);
        chk("rst_err", {21'd0, sticky0, sticky1, cnt_o0, cnt_o1}, 32'd0);
        clr = 1'b0;

        // Fixed vectors
        foreach (vecs[i])
            do_word(vecs[i].q_pre, vecs[i].target, vecs[i].stk, 1'b0,
                    vecs[i].j_dc0, vecs[i].k_dc0, vecs[i].j_dc1, vecs[i].k_dc1, vecs[i].mis);

        // Saturation of the 2-bit counter, then a clear colliding with a mismatch
        for (int n = 0; n < 5; n++)
            do_word(8'h00, 8'h01, 8'h01, 1'b0, 8'h01, 8'h00, 8'h01, 8'hFF, 1'b1);
        chk("sat_count1", cnt_o1, 32'd3);
        chk("count0_7", cnt_o0, 32'd7);
        do_word(8'h00, 8'h01, 8'h01, 1'b1, 8'h01, 8'h00, 8'h01, 8'hFF, 1'b1);

        // Randomized words against the reference model
        for (int n = 0; n < 40; n++) begin
            rq = 8'($urandom);
            rt = 8'($urandom);
            rs = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            rc = ($urandom_range(0, 7) == 0);
            ref_exc(rq, rt, 1'b0, ej0, ek0);
            ref_exc(rq, rt, 1'b1, ej1, ek1);
            do_word(rq, rt, rs, rc, ej0, ek0, ej1, ek1, |(rt & rs));
        end

        // Guarantee a non-zero error state, then reset in the middle of DRIVE
        do_word(8'h00, 8'h01, 8'h01, 1'b0, 8'h01, 8'h00, 8'h01, 8'hFF, 1'b1);
        stuck = 8'h00;
        in_valid = 1'b1; in_target = 8'hFF;
        @(negedge clk);
        in_valid = 1'b0;
        clr = 1'b1;
        m_cnt0 = 0; m_cnt1 = 0; m_st0 = 1'b0; m_st1 = 1'b0;
        @(negedge clk);
        $display("reset mid-DRIVE");
        chk("mid_rst_ready", {30'd0, in_ready1, in_ready0}, 32'd3);
        chk("mid_rst_jk", {j0, k0, j1, k1}, 32'd0);
        chk("mid_rst_err", {21'd0, sticky0, sticky1, cnt_o0, cnt_o1}, 32'd0);
        chk("mid_rst_done_a", {30'd0, done1, done0}, 32'd0);
        @(negedge clk);
        chk("mid_rst_done_b", {30'd0, done1, done0}, 32'd0);
        clr = 1'b0;
        @(negedge clk);
        chk("mid_rst_done_c", {30'd0, done1, done0}, 32'd0);
        @(negedge clk);
        chk("mid_rst_done_d", {30'd0, done1, done0}, 32'd0);

        // Back-to-back: in_valid held across four words
        words[0] = 8'h11; words[1] = 8'hC3; words[2] = 8'h5E; words[3] = 8'h96;
        begin
            int base;
            base = done_cnt;
            in_valid = 1'b1;
            for (int w = 0; w < 4; w++) begin
                in_target = words[w];
                @(negedge clk);
                chk("b2b_busy1", in_ready0, 32'd0);
                @(negedge clk);
                chk("b2b_busy2", in_ready0, 32'd0);
                @(negedge clk);
                if (w == 3) in_valid = 1'b0;
                $display("b2b word %0d target=%h done=%0d ready=%0d", w, words[w], done0, in_ready0);
                chk("b2b_done", {30'd0, done1, done0}, 32'd3);
                chk("b2b_ready", {30'd0, in_ready1, in_ready0}, 32'd3);
                chk("b2b_mis", {30'd0, mis1, mis0}, 32'd0);
            end
            @(negedge clk);
            chk("b2b_done_count", done_cnt - base, 32'd4);
            chk("b2b_bank0", bank0, words[3]);
            chk("b2b_bank1", bank1, words[3]);
            chk("b2b_idle_done", {30'd0, done1, done0}, 32'd0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
